// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte output, frame-error and overrun pulses
// Ports:
//   clk_i        system clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   rxd_i        serial line, asynchronous to clk_i, idle high
//   rvalid_o     received byte available in rdata_o
//   rready_i     consumer accepts the byte when rvalid_o & rready_i
//   rdata_o      received byte, stable while rvalid_o is high
//   frame_err_o  one-cycle pulse when the stop bit is sampled low
//   overrun_o    one-cycle pulse when a completed byte is dropped
//   busy_o       high whenever the receiver is not idle
module uart_rx #(
   parameter int CLK_FREQ_MHZ = 100,
   parameter int BAUD_RATE    = 1000000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rxd_i,
   output logic       rvalid_o,
   input  logic       rready_i,
   output logic [7:0] rdata_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);
   localparam int BIT_CYCLES = CLK_FREQ_MHZ * 1000000 / BAUD_RATE;
   localparam int HALF       = BIT_CYCLES / 2;
   localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] BIT_LD  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic [1:0]    sync_q;
   logic          rx_d;
   logic [2:0]    arm_q;
   logic          rx_s, fall, tick, done, ferr, accept;

   assign rx_s = sync_q[1];
   assign tick = cnt_q == '0;
   // The synchronizer resets to 1, so the first few samples after reset are not
   // real line history; arming edge detection only once rx_d holds a real sample
   // keeps a line that is already low at release from looking like a start edge.
   assign fall = arm_q[2] & rx_d & ~rx_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         sync_q  <= 2'b11;
         rx_d    <= 1'b1;
         arm_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         sync_q  <= {sync_q[0], rxd_i};
         rx_d    <= rx_s;
         arm_q   <= {arm_q[1:0], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      unique case (state_q)
         IDLE:  if (fall) begin
            state_d = START;
            cnt_d   = HALF_LD;
         end
         START: if (tick) begin
            state_d = rx_s ? IDLE : DATA;
            cnt_d   = BIT_LD;
            idx_d   = '0;
         end
         DATA:  if (tick) begin
            sh_d[idx_q] = rx_s;
            cnt_d       = BIT_LD;
            idx_d       = idx_q + 3'd1;
            state_d     = (idx_q == 3'd7) ? STOP : DATA;
         end
         STOP:  if (tick) state_d = rx_s ? IDLE : BREAK;
         BREAK: if (rx_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = state_q != IDLE;
      done   = (state_q == STOP) & tick & rx_s;
      ferr   = (state_q == STOP) & tick & ~rx_s;
      accept = ~rvalid_o | rready_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_o    <= 1'b0;
         rdata_o     <= '0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         rvalid_o    <= done | (rvalid_o & ~rready_i);
         rdata_o     <= (done & accept) ? sh_q : rdata_o;
         frame_err_o <= ferr;
         overrun_o   <= done & ~accept;
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level reference
module tb_uart_rx;
   localparam int BIT  = 100;
   localparam int HALF = BIT / 2;
   localparam int LAT  = 2 + HALF + 9 * BIT;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       rxd_i = 1'b1;
   logic       rready_i = 1'b0;
   logic       rvalid_o, frame_err_o, overrun_o, busy_o;
   logic [7:0] rdata_o;

   int         checks = 0;
   int         fails = 0;
   int         fe_hi = 0;
   int         ov_hi = 0;
   bit         abort_tx = 1'b0;
   logic [7:0] got[$];

   uart_rx dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .rxd_i(rxd_i), .rvalid_o(rvalid_o),
      .rready_i(rready_i), .rdata_o(rdata_o), .frame_err_o(frame_err_o),
      .overrun_o(overrun_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (rvalid_o && rready_i) got.push_back(rdata_o);
         if (frame_err_o) fe_hi++;
         if (overrun_o) ov_hi++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (abort_tx) break;
         rxd_i = f[i];
         step(BIT);
      end
      if (abort_tx) rxd_i = 1'b1;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!rvalid_o && n < limit) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (rvalid_o !== 1'b0) begin fails++; $display("FAIL %s_rvalid: got %0b want 0", tag, rvalid_o); end
      checks++;
      if (rdata_o !== 8'h00) begin fails++; $display("FAIL %s_rdata: got %h want 00", tag, rdata_o); end
      checks++;
      if (frame_err_o !== 1'b0) begin fails++; $display("FAIL %s_frame_err: got %0b want 0", tag, frame_err_o); end
      checks++;
      if (overrun_o !== 1'b0) begin fails++; $display("FAIL %s_overrun: got %0b want 0", tag, overrun_o); end
      checks++;
      if (busy_o !== 1'b0) begin fails++; $display("FAIL %s_busy: got %0b want 0", tag, busy_o); end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      step(3);
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      step(5);
   endtask

   task automatic test_single();
      int n;
      got.delete();
      rready_i = 1'b0;
      fork
         send_frame(8'hA5, 1'b1);
         wait_valid(1200, n);
      join
      checks++;
      if (n - 1 < LAT - 2 || n - 1 > LAT + 2) begin
         fails++; $display("FAIL single_latency: got %0d want %0d+/-2", n - 1, LAT);
      end
      checks++;
      if (rdata_o !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", rdata_o); end
      step(50);
      checks++;
      if (rvalid_o !== 1'b1 || rdata_o !== 8'hA5) begin
         fails++; $display("FAIL single_hold: got valid=%0b data=%h want valid=1 data=a5", rvalid_o, rdata_o);
      end
      rready_i = 1'b1;
      step(1);
      rready_i = 1'b0;
      checks++;
      if (rvalid_o !== 1'b0) begin fails++; $display("FAIL single_clear: got %0b want 0", rvalid_o); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[3];
      int fe0, ov0;
      exp = '{8'h00, 8'hFF, 8'h3C};
      got.delete();
      fe0 = fe_hi;
      ov0 = ov_hi;
      rready_i = 1'b1;
      foreach (exp[i]) send_frame(exp[i], 1'b1);
      step(200);
      checks++;
      if (got.size() != 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
      checks++;
      if (fe_hi != fe0 || ov_hi != ov0) begin
         fails++; $display("FAIL b2b_flags: got fe=%0d ov=%0d want 0 0", fe_hi - fe0, ov_hi - ov0);
      end
   endtask

   task automatic test_glitch();
      bit seen_busy;
      seen_busy = 1'b0;
      got.delete();
      rready_i = 1'b1;
      rxd_i = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         seen_busy |= busy_o;
      end
      rxd_i = 1'b1;
      for (int i = 0; i < 25; i++) begin
         step(1);
         seen_busy |= busy_o;
      end
      checks++;
      if (seen_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_seen: got 0 want 1"); end
      checks++;
      if (busy_o !== 1'b0) begin fails++; $display("FAIL glitch_busy_idle: got %0b want 0", busy_o); end
      step(1000);
      checks++;
      if (got.size() != 0) begin fails++; $display("FAIL glitch_no_byte: got %0d bytes want 0", got.size()); end
      send_frame(8'h5A, 1'b1);
      step(100);
      checks++;
      if (got.size() != 1 || got[0] !== 8'h5A) begin
         fails++; $display("FAIL glitch_next: got %0d bytes first=%h want 1 byte 5a", got.size(), got.size() ? got[0] : 8'h00);
      end
   endtask

   task automatic test_frame_err();
      int fe0;
      got.delete();
      fe0 = fe_hi;
      rready_i = 1'b1;
      send_frame(8'h81, 1'b0);
      step(400);
      checks++;
      if (fe_hi - fe0 != 1) begin fails++; $display("FAIL ferr_pulse: got %0d cycles want 1", fe_hi - fe0); end
      checks++;
      if (busy_o !== 1'b1) begin fails++; $display("FAIL ferr_busy_low_line: got %0b want 1", busy_o); end
      checks++;
      if (got.size() != 0 || rvalid_o !== 1'b0) begin
         fails++; $display("FAIL ferr_no_byte: got %0d bytes valid=%0b want 0 0", got.size(), rvalid_o);
      end
      rxd_i = 1'b1;
      step(10);
      checks++;
      if (busy_o !== 1'b0) begin fails++; $display("FAIL ferr_busy_release: got %0b want 0", busy_o); end
      send_frame(8'h42, 1'b1);
      step(100);
      checks++;
      if (got.size() != 1 || got[0] !== 8'h42) begin
         fails++; $display("FAIL ferr_next: got %0d bytes first=%h want 1 byte 42", got.size(), got.size() ? got[0] : 8'h00);
      end
   endtask

   task automatic test_overrun();
      int ov0;
      got.delete();
      ov0 = ov_hi;
      rready_i = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      step(100);
      checks++;
      if (ov_hi - ov0 != 1) begin fails++; $display("FAIL ovr_pulse: got %0d cycles want 1", ov_hi - ov0); end
      checks++;
      if (rdata_o !== 8'h11 || rvalid_o !== 1'b1) begin
         fails++; $display("FAIL ovr_keep: got data=%h valid=%0b want 11 1", rdata_o, rvalid_o);
      end
      rready_i = 1'b1;
      step(1);
      rready_i = 1'b0;
      got.delete();
      ov0 = ov_hi;
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            step(LAT - 3);
            rready_i = 1'b1;
            step(7);
            rready_i = 1'b0;
         end
      join
      step(100);
      checks++;
      if (ov_hi != ov0) begin fails++; $display("FAIL ovr_ready_pulse: got %0d cycles want 0", ov_hi - ov0); end
      checks++;
      if (rdata_o !== 8'h22) begin fails++; $display("FAIL ovr_ready_data: got %h want 22", rdata_o); end
      checks++;
      if (got.size() != 2 || got[1] !== 8'h22) begin
         fails++; $display("FAIL ovr_ready_xfer: got %0d transfers want 2 ending 22", got.size());
      end
   endtask

   task automatic test_reset_mid();
      got.delete();
      rready_i = 1'b1;
      abort_tx = 1'b0;
      fork
         send_frame(8'h77, 1'b1);
         begin
            step(5 * BIT + HALF);
            rst_ni = 1'b0;
            #1;
            check_reset_outputs("rstmid");
            step(3);
            rst_ni = 1'b1;
            abort_tx = 1'b1;
         end
      join
      abort_tx = 1'b0;
      step(1200);
      checks++;
      if (got.size() != 0 || busy_o !== 1'b0) begin
         fails++; $display("FAIL rstmid_no_byte: got %0d bytes busy=%0b want 0 0", got.size(), busy_o);
      end
      send_frame(8'h99, 1'b1);
      step(100);
      checks++;
      if (got.size() != 1 || got[0] !== 8'h99) begin
         fails++; $display("FAIL rstmid_next: got %0d bytes first=%h want 1 byte 99", got.size(), got.size() ? got[0] : 8'h00);
      end
   endtask

   task automatic test_reset_low();
      got.delete();
      rready_i = 1'b1;
      rst_ni = 1'b0;
      rxd_i = 1'b0;
      step(3);
      rst_ni = 1'b1;
      step(200);
      checks++;
      if (busy_o !== 1'b0) begin fails++; $display("FAIL rstlow_no_start: got busy=%0b want 0", busy_o); end
      rxd_i = 1'b1;
      step(1100);
      checks++;
      if (got.size() != 0) begin fails++; $display("FAIL rstlow_no_byte: got %0d bytes want 0", got.size()); end
   endtask

   task automatic test_random();
      logic [7:0] exp[$];
      logic [7:0] b;
      got.delete();
      rready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         send_frame(b, 1'b1);
         step($urandom_range(0, 40));
      end
      step(100);
      checks++;
      if (got.size() != exp.size()) begin
         fails++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin fails++; $display("FAIL rand_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      test_reset_low();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
